multich_seizure_detect: RTL

Parametrised multi-channel successor to the single-channel seizure datapath. Accepts time-multiplexed iEEG samples from NUM_CH electrodes and computes a block line-length feature per channel over 2^LOG_WIN samples. Each channel's feature is compared against its own runtime-programmable threshold. When at least MIN_CH channels have each exceeded threshold for HITS_REQ consecutive windows, a stimulation pulse of programmable duration is issued, followed by a refractory lockout. It sits between the ADC sample interface and the stimulator driver.

---
 rtl/seizure_pkg.sv | 20 ++
 rtl/stim_ctrl.sv | 88 ++++++++
 rtl/multich_seizure_detect.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seizure_pkg.sv
// Shared types and width helpers for the multi-channel seizure detector.
package seizure_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STIM    = 2'd1,
      ST_REFRACT = 2'd2
   } stim_state_t;

   // Index width that never collapses to zero bits for a single channel.
   function automatic int clog2_min1(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

   // Line-length accumulator width: one window of full-scale diffs never wraps.
   function automatic int ll_width(input int data_width, input int log_win);
      return data_width + 1 + log_win;
   endfunction

endpackage

// File: rtl/stim_ctrl.sv
// Vote on per-channel flags and sequence the stimulation pulse and lockout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for at least MIN_CH flagged channels
// ST_STIM    | stimulation high, counting down STIM_CYCLES
// ST_REFRACT | refractory high, counting down REFRACT_CYCLES, no retrigger
module stim_ctrl
   import seizure_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int MIN_CH         = 2,
   parameter int STIM_CYCLES    = 1000,
   parameter int REFRACT_CYCLES = 30000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_flag,
   output logic              stimulation,
   output logic              refractory
);

   localparam int MAX_CYC = (STIM_CYCLES > REFRACT_CYCLES) ? STIM_CYCLES : REFRACT_CYCLES;
   localparam int CNT_W   = clog2_min1(MAX_CYC);
   localparam int VOTE_W  = clog2_min1(NUM_CH + 1);
   localparam logic [CNT_W-1:0] STIM_LOAD = CNT_W'(STIM_CYCLES - 1);
   localparam logic [CNT_W-1:0] REFR_LOAD = CNT_W'(REFRACT_CYCLES - 1);

   stim_state_t       state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [VOTE_W-1:0] votes;
   logic              vote_ok;

   // Count flagged channels.
   always_comb begin
      votes = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         votes = votes + VOTE_W'(ch_flag[i]);
      end
      vote_ok = (32'(votes) >= 32'(MIN_CH));
   end

   // State and duration down-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Next state, counter reload/decrement and Moore outputs.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      stimulation = 1'b0;
      refractory  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (vote_ok) begin
               state_n = ST_STIM;
               cnt_n   = STIM_LOAD;
            end
         end
         ST_STIM: begin
            stimulation = 1'b1;
            if (cnt == '0) begin
               state_n = ST_REFRACT;
               cnt_n   = REFR_LOAD;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_REFRACT: begin
            refractory = 1'b1;
            if (cnt == '0) begin
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/multich_seizure_detect.sv
// Time-multiplexed per-channel line-length detector with voting stimulation.
// Stage 1 registers the accepted sample and any threshold write; stage 2 does
// the per-channel read/modify/write and publishes completed windows.
module multich_seizure_detect
   import seizure_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int NUM_CH         = 4,
   parameter int LOG_WIN        = 8,
   parameter int LL_WIDTH       = ll_width(DATA_WIDTH, LOG_WIN),
   parameter int HITS_REQ       = 3,
   parameter int MIN_CH         = 2,
   parameter int STIM_CYCLES    = 1000,
   parameter int REFRACT_CYCLES = 30000,
   parameter int CH_W           = clog2_min1(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         din_valid,
   input  logic [CH_W-1:0]              din_ch,
   input  logic signed [DATA_WIDTH-1:0] din,
   input  logic                         thr_we,
   input  logic [CH_W-1:0]              thr_ch,
   input  logic [LL_WIDTH-1:0]          thr_data,
   output logic                         ll_valid,
   output logic [CH_W-1:0]              ll_ch,
   output logic [LL_WIDTH-1:0]          ll_value,
   output logic [NUM_CH-1:0]            ch_flag,
   output logic                         stimulation,
   output logic                         refractory
);

   localparam int DIFF_W = DATA_WIDTH + 1;
   localparam int HIT_W  = clog2_min1(HITS_REQ + 1);
   localparam int IDX_W  = clog2_min1(NUM_CH);
   localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);
   localparam logic [HIT_W-1:0] HIT_SAT  = HIT_W'(HITS_REQ);

   logic                         s_valid;
   logic [IDX_W-1:0]             s_idx;
   logic signed [DATA_WIDTH-1:0] s_din;
   logic                         w_valid;
   logic [IDX_W-1:0]             w_idx;
   logic [LL_WIDTH-1:0]          w_data;

   logic signed [DATA_WIDTH-1:0] prev_q [NUM_CH];
   logic                         prev_ok [NUM_CH];
   logic [LOG_WIN-1:0]           cnt_q [NUM_CH];
   logic [LL_WIDTH-1:0]          acc_q [NUM_CH];
   logic [HIT_W-1:0]             hit_q [NUM_CH];
   logic [LL_WIDTH-1:0]          thr_q [NUM_CH];
   logic [NUM_CH-1:0]            flag_q;

   logic signed [DIFF_W-1:0] cur_ext, prev_ext;
   logic [DIFF_W-1:0]        diff;
   logic [LL_WIDTH-1:0]      sum;
   logic                     win_end, above;
   logic [HIT_W-1:0]         hit_n;

   // Input stage: out-of-range channels never reach the channel state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_valid <= 1'b0;
         s_idx   <= '0;
         s_din   <= '0;
         w_valid <= 1'b0;
         w_idx   <= '0;
         w_data  <= '0;
      end else begin
         s_valid <= en && din_valid && ({1'b0, din_ch} < CH_LIMIT);
         s_idx   <= din_ch[IDX_W-1:0];
         s_din   <= din;
         w_valid <= thr_we && ({1'b0, thr_ch} < CH_LIMIT);
         w_idx   <= thr_ch[IDX_W-1:0];
         w_data  <= thr_data;
      end
   end

   // Exact |din - prev| at DATA_WIDTH+1 bits, window sum and threshold compare.
   always_comb begin
      prev_ext = {prev_q[s_idx][DATA_WIDTH-1], prev_q[s_idx]};
      cur_ext  = {s_din[DATA_WIDTH-1], s_din};
      diff     = '0;
      if (prev_ok[s_idx]) begin
         diff = (cur_ext >= prev_ext) ? cur_ext - prev_ext : prev_ext - cur_ext;
      end
      sum     = acc_q[s_idx] + {{(LL_WIDTH - DIFF_W){1'b0}}, diff};
      win_end = &cnt_q[s_idx];
      above   = sum > thr_q[s_idx];
      hit_n   = '0;
      if (above) begin
         hit_n = (hit_q[s_idx] >= HIT_SAT) ? HIT_SAT : hit_q[s_idx] + 1'b1;
      end
   end

   // Per-channel state update and window publication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            prev_q[i]  <= '0;
            prev_ok[i] <= 1'b0;
            cnt_q[i]   <= '0;
            acc_q[i]   <= '0;
            hit_q[i]   <= '0;
         end
         flag_q   <= '0;
         ll_valid <= 1'b0;
         ll_ch    <= '0;
         ll_value <= '0;
      end else begin
         ll_valid <= 1'b0;
         if (s_valid) begin
            prev_q[s_idx]  <= s_din;
            prev_ok[s_idx] <= 1'b1;
            cnt_q[s_idx]   <= cnt_q[s_idx] + 1'b1;
            if (win_end) begin
               acc_q[s_idx]  <= '0;
               hit_q[s_idx]  <= hit_n;
               flag_q[s_idx] <= (hit_n >= HIT_SAT);
               ll_valid      <= 1'b1;
               ll_ch         <= CH_W'(s_idx);
               ll_value      <= sum;
            end else begin
               acc_q[s_idx] <= sum;
            end
         end
      end
   end

   // Threshold file; the staged write lands after any coincident compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            thr_q[i] <= '1;
         end
      end else if (w_valid) begin
         thr_q[w_idx] <= w_data;
      end
   end

   assign ch_flag = flag_q;

   stim_ctrl #(
      .NUM_CH         (NUM_CH),
      .MIN_CH         (MIN_CH),
      .STIM_CYCLES    (STIM_CYCLES),
      .REFRACT_CYCLES (REFRACT_CYCLES)
   ) u_stim_ctrl (
      .clk         (clk),
      .rst         (rst),
      .ch_flag     (flag_q),
      .stimulation (stimulation),
      .refractory  (refractory)
   );

endmodule
